// File: rtl/vfpu_pkg.sv
// Shared definitions for the sequential fp16 vector FPU: op encodings, FSM states, fp16 constants.
package vfpu_pkg;

  localparam logic [1:0] OP_VADD = 2'b00;
  localparam logic [1:0] OP_VDOT = 2'b01;
  localparam logic [1:0] OP_SMUL = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  localparam logic [15:0] FP16_ZERO    = 16'h0000;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

  function automatic logic is_inf_nan(input logic [15:0] x);
    return x[14:10] == FP16_EXP_MAX;
  endfunction

endpackage

// File: rtl/fp16_mul.sv
// Combinational fp16 multiplier, round-to-nearest-even, subnormal inputs and results flushed to zero.
module fp16_mul
  import vfpu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic [4:0]  ea, eb;
  logic [21:0] p;
  logic [9:0]  m;
  logic [10:0] mr;
  logic        sign, g, s, rnd;
  logic signed [7:0] e;

  always_comb begin
    sign = a[15] ^ b[15];
    ea   = a[14:10];
    eb   = b[14:10];
    p    = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e    = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
    if (p[21]) begin
      m = p[20:11];
      g = p[10];
      s = |p[9:0];
      e = e + 8'sd1;
    end else begin
      m = p[19:10];
      g = p[9];
      s = |p[8:0];
    end
    rnd = g & (s | m[0]);
    mr  = {1'b0, m} + 11'(rnd);
    if (mr[10]) e = e + 8'sd1;
    y = {sign, e[4:0], mr[9:0]};
    if (ea == FP16_EXP_MAX || eb == FP16_EXP_MAX) begin
      // inf*0 and any NaN operand give the canonical quiet NaN
      if ((ea == FP16_EXP_MAX && a[9:0] != 10'd0) || (eb == FP16_EXP_MAX && b[9:0] != 10'd0) ||
          ea == 5'd0 || eb == 5'd0) y = FP16_QNAN;
      else y = {sign, FP16_EXP_MAX, 10'd0};
    end else if (ea == 5'd0 || eb == 5'd0 || e <= 8'sd0) begin
      y = {sign, 15'd0};
    end else if (e >= 8'sd31) begin
      y = {sign, FP16_EXP_MAX, 10'd0};
    end
  end

endmodule

// File: rtl/fp_adder.sv
// Combinational fp16 adder, round-to-nearest-even, subnormal inputs and results flushed to zero.
module fp_adder
  import vfpu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic [15:0] x, z;
  logic [4:0]  ex, ez, d, msb;
  logic [24:0] bfull, bs;
  logic [25:0] ax, bz, sum, norm;
  logic [10:0] mr;
  logic        sub, sticky, rnd;
  logic signed [7:0] e;

  always_comb begin
    // x always carries the larger magnitude so the difference is never negative
    if (b[14:0] > a[14:0]) begin
      x = b;
      z = a;
    end else begin
      x = a;
      z = b;
    end
    ex     = x[14:10];
    ez     = z[14:10];
    d      = ex - ez;
    ax     = (ex == 5'd0) ? 26'd0 : {1'b0, 1'b1, x[9:0], 14'd0};
    bfull  = (ez == 5'd0) ? 25'd0 : {1'b1, z[9:0], 14'd0};
    bs     = bfull >> d;
    sticky = |(bfull & ~({25{1'b1}} << d));
    bz     = {1'b0, bs[24:1], bs[0] | sticky};
    sub    = x[15] ^ z[15];
    sum    = sub ? (ax - bz) : (ax + bz);
    msb    = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (sum[i]) msb = 5'(i);
    end
    norm = sum << (5'd25 - msb);
    e    = $signed({3'b000, ex}) + $signed({3'b000, msb}) - 8'sd24;
    rnd  = norm[14] & ((|norm[13:0]) | norm[15]);
    mr   = {1'b0, norm[24:15]} + 11'(rnd);
    if (mr[10]) e = e + 8'sd1;
    y = {x[15], e[4:0], mr[9:0]};
    if (ex == FP16_EXP_MAX) begin
      if (x[9:0] != 10'd0 || (ez == FP16_EXP_MAX && (z[9:0] != 10'd0 || sub))) y = FP16_QNAN;
      else y = {x[15], FP16_EXP_MAX, 10'd0};
    end else if (sum == 26'd0) begin
      y = {x[15] & ~sub, 15'd0};
    end else if (e >= 8'sd31) begin
      y = {x[15], FP16_EXP_MAX, 10'd0};
    end else if (e <= 8'sd0) begin
      y = {x[15], 15'd0};
    end
  end

endmodule

// File: rtl/vfpu_seq.sv
// Multi-cycle fp16 vector FPU (VADD, SMUL, in-order VDOT) with start/busy/done handshake.
// Optional sticky inf/NaN flag on ovf when VFPU_OVF_FLAGS_EN is defined.
module vfpu_seq
  import vfpu_pkg::*;
#(
  parameter int unsigned LANES = 16,
  parameter int unsigned PAR   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [LANES*16-1:0] Va,
  input  logic [LANES*16-1:0] Vb,
  input  logic [15:0]         Sa,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [LANES*16-1:0] Vout,
  output logic [15:0]         Sout,
  output logic                ovf
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned NB = LANES / PAR;

  if (LANES % PAR != 0) begin : g_par_check
    $error("vfpu_seq: PAR must divide LANES");
  end

  state_t        state;
  logic [1:0]    op_q;
  logic [15:0]   sa_q, acc;
  logic [15:0]   va_in [LANES];
  logic [15:0]   vb_in [LANES];
  logic [15:0]   va_q  [LANES];
  logic [15:0]   vb_q  [LANES];
  logic [15:0]   vout_q[LANES];
  logic [LW-1:0] beat;
  logic [LW-1:0] lane  [PAR];
  logic [15:0]   res   [PAR];
  logic          is_dot, last_beat;

  assign is_dot    = (op_q == OP_VDOT);
  assign last_beat = is_dot ? (beat == LW'(LANES - 1)) : (beat == LW'(NB - 1));

  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign va_in[g]            = Va[16*g +: 16];
    assign vb_in[g]            = Vb[16*g +: 16];
    assign Vout[16*g +: 16]    = vout_q[g];
  end

  // Lane 0's multiplier and adder double as the VDOT product and accumulator path
  for (genvar p = 0; p < PAR; p++) begin : g_lane
    logic [15:0] mul_a, mul_b, mul_y, add_a, add_b, add_y;
    assign lane[p] = LW'(int'(beat) * int'(PAR) + p);
    if (p == 0) begin : g_shared
      assign mul_a = is_dot ? va_q[beat] : va_q[lane[p]];
      assign mul_b = is_dot ? vb_q[beat] : sa_q;
      assign add_a = is_dot ? mul_y : va_q[lane[p]];
      assign add_b = is_dot ? acc : vb_q[lane[p]];
    end else begin : g_plain
      assign mul_a = va_q[lane[p]];
      assign mul_b = sa_q;
      assign add_a = va_q[lane[p]];
      assign add_b = vb_q[lane[p]];
    end
    fp16_mul u_mul (.a(mul_a), .b(mul_b), .y(mul_y));
    fp_adder u_add (.a(add_a), .b(add_b), .y(add_y));
    assign res[p] = (op_q == OP_SMUL) ? mul_y : add_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      op_q   <= OP_VADD;
      sa_q   <= FP16_ZERO;
      acc    <= FP16_ZERO;
      beat   <= '0;
      Sout   <= FP16_ZERO;
      va_q   <= '{default: FP16_ZERO};
      vb_q   <= '{default: FP16_ZERO};
      vout_q <= '{default: FP16_ZERO};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            va_q  <= va_in;
            vb_q  <= vb_in;
            sa_q  <= Sa;
            op_q  <= op;
            beat  <= '0;
            acc   <= FP16_ZERO;
            busy  <= 1'b1;
            err   <= 1'b0;
            if (op == OP_ILL) begin
              state  <= ERR;
              done   <= 1'b1;
              err    <= 1'b1;
              Sout   <= FP16_ZERO;
              vout_q <= '{default: FP16_ZERO};
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (is_dot) acc <= res[0];
          else begin
            for (int p = 0; p < int'(PAR); p++) vout_q[lane[p]] <= res[p];
          end
          beat <= beat + LW'(1);
          if (last_beat) begin
            state <= DONE;
            done  <= 1'b1;
            if (is_dot) begin
              Sout   <= res[0];
              vout_q <= '{default: FP16_ZERO};
            end else begin
              Sout <= FP16_ZERO;
            end
          end
        end
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VFPU_OVF_FLAGS_EN
  logic ovf_hit;

  always_comb begin
    ovf_hit = 1'b0;
    if (is_dot) ovf_hit = is_inf_nan(res[0]);
    else begin
      for (int p = 0; p < int'(PAR); p++) ovf_hit = ovf_hit | is_inf_nan(res[p]);
    end
  end

  // Sticky until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (state == IDLE && start) ovf <= 1'b0;
    else if (state == RUN && ovf_hit) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/vfpu_seq.md
Name: vfpu_seq

Overview:
Multi-cycle, parametrised half-precision (fp16) vector FPU. It succeeds the single-cycle combinational vector unit.
- Processes LANES elements through PAR physical lane units per cycle, under a start/busy/done handshake.
- Supports three ops: vector add, scalar-vector multiply, and dot product.
- Adds a fixed-order dot-product reduction and an explicit illegal-op error.
- Sits between the register file / decode stage and the writeback mux.

Parameters:
- LANES, 16, number of fp16 elements per vector (vector width = LANES*16 bits).
- PAR, 4, lanes computed per cycle for VADD/SMUL. Must divide LANES (elaboration-time check).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only while busy=0.
- op  input  2  operation: 00 VADD, 01 VDOT, 10 SMUL, 11 illegal.
- Va  input  LANES*16  vector operand A; lane i is bits [16i+15:16i].
- Vb  input  LANES*16  vector operand B.
- Sa  input  16  scalar operand for SMUL.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle completion pulse.
- err  output  1  set with done when op=11.
- Vout  output  LANES*16  vector result.
- Sout  output  16  scalar result (VDOT).
- ovf  output  1  sticky inf/NaN flag (only with the optional feature).

Behaviour:
- Reset (async, any time, including mid-operation): state IDLE; busy, done, err, ovf = 0; Vout, Sout = 0; accumulator = 0; internal operand copies cleared.
- FSM states and transitions:
  - IDLE: on start=1, capture Va, Vb, Sa, op into internal registers and clear the beat counter. Go to RUN (op 00/01/10) or ERR (op 11).
  - RUN: one beat per cycle.
    - VADD/SMUL beat k writes lanes k*PAR .. k*PAR+PAR-1 of Vout. VADD computes Va+Vb per lane; SMUL computes Va*Sa per lane. N = LANES/PAR beats.
    - VDOT beat k computes acc = acc + Va[k]*Vb[k]. One lane per cycle, strictly lane 0 to LANES-1 (fixed rounding order). N = LANES beats; acc starts at +0 (0x0000).
    - After the last beat go to DONE.
  - DONE: done=1 for exactly this cycle. VDOT writes Sout = acc and Vout = 0. VADD/SMUL leave Sout = 0. Go to IDLE.
  - ERR: done=1 and err=1 for one cycle; Vout = 0, Sout = 0. Go to IDLE.
- Handshake:
  - busy=1 in RUN, DONE and ERR.
  - start while busy=1 is ignored, not queued.
  - start in the same cycle as done is ignored. A new op is accepted the cycle after done.
- Latency: start sampled at edge 0; done is high in cycle N+1 (VADD/SMUL: LANES/PAR+1; VDOT: LANES+1; illegal: 1).
- Output holding:
  - Vout/Sout hold their last result until the next accepted start.
  - On an accepted start, lanes not yet written read the previous result. Consumers use Vout/Sout only after done.
- Input changes after capture have no effect on the op in flight.
- err clears on the next accepted start.
- Arithmetic: fp16 IEEE layout, round-to-nearest-even, same semantics as the existing fp_adder. Subnormals flush to zero.

Optional Feature:
- Macro: VFPU_OVF_FLAGS_EN.
- When defined: ovf is set if any written lane result or the accumulator has exponent 5'b11111 (inf/NaN). It stays set until the next accepted start or reset.
- When undefined: ovf is tied to 0 and no detection logic is built.

Decomposition:
- Shared package vfpu_pkg holds:
  - op encodings: OP_VADD=2'b00, OP_VDOT=2'b01, OP_SMUL=2'b10, OP_ILL=2'b11;
  - FSM state typedef: IDLE, RUN, DONE, ERR;
  - fp16 constants: FP16_ZERO=16'h0000, FP16_EXP_MAX=5'h1F.
- Sub-module fp16_mul: one fp16 multiplier, instantiated PAR times. Lane 0's instance is shared with VDOT.
- The existing fp_adder is reused PAR times; lane 0's adder serves as the VDOT accumulator adder.

Test Plan:
- VADD, LANES=16, PAR=4, all lanes Va=0x3C00, Vb=0x3C00 -> done in cycle 5, every Vout lane = 0x4000, Sout=0, err=0.
- SMUL, Va all 0x4000, Sa=0x4200 -> done in cycle 5, every Vout lane = 0x4600.
- VDOT, Va all 0x3C00, Vb all 0x4000 -> done in cycle 17, Sout=0x5000, Vout=0.
- op=11 -> done and err high in cycle 1; Vout=0, Sout=0; next VADD clears err.
- VDOT started, rst pulsed at cycle 8 -> busy, done, Sout, Vout all 0 immediately. A second start pulsed at cycle 3 of an earlier VADD is ignored, and done still arrives in cycle 5.
- With VFPU_OVF_FLAGS_EN: VADD Va lane 0 = 0x7BFF, Vb lane 0 = 0x7BFF -> Vout lane 0 = 0x7C00, ovf=1 until next start. Without the macro, ovf stays 0.
